// File: rtl/ro_pkg.sv
// Shared defaults and types for the ring-oscillator edge counter slice.
package ro_pkg;

  localparam int unsigned RO_CNT_W       = 32;
  localparam int unsigned RO_SYNC_STAGES = 2;

  typedef logic [RO_CNT_W-1:0] count_t;

endpackage

// File: rtl/ro_edge_counter_if.sv
// Valid/ready sample channel from the edge counter to the UART framer.
interface ro_edge_counter_if
  import ro_pkg::*;
#(
  parameter int unsigned CNT_W = RO_CNT_W
);

  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] m_count;
  logic             m_sat;
  logic             m_overrun;

  modport master (
    output m_valid,
    output m_count,
    output m_sat,
    output m_overrun,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_count,
    input  m_sat,
    input  m_overrun,
    output m_ready
  );

endinterface

// File: rtl/ro_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module ro_sync_edge
  import ro_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = RO_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync[0] <= async_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/ro_edge_counter.sv
// Counts synchronised ring-oscillator edges per measurement window and presents
// one saturating sample per window on a valid/ready channel with overrun reporting.
module ro_edge_counter
  import ro_pkg::*;
#(
  parameter int unsigned CNT_W       = RO_CNT_W,
  parameter int unsigned SYNC_STAGES = RO_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  ro_in,
  input  logic                  window_done,
  ro_edge_counter_if.master     m_if
);

  logic             w_rise;
  logic             w_acc_full;
  logic             w_load;
  logic [CNT_W-1:0] w_snap;
  logic             w_snap_sat;

  logic [CNT_W-1:0] r_acc;
  logic             r_sat;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;
  logic             r_msat;
  logic             r_overrun;

  ro_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ro_in),
    .rise     (w_rise)
  );

  // A rise coincident with window_done is folded into the closing window's snapshot.
  always_comb begin
    w_acc_full = &r_acc;
    w_load     = en & window_done;
    w_snap     = w_acc_full ? r_acc : r_acc + CNT_W'(w_rise);
    w_snap_sat = r_sat | (w_acc_full & w_rise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (!en || window_done) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (w_rise) begin
      if (w_acc_full) begin
        r_sat <= 1'b1;
      end else begin
        r_acc <= r_acc + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_count   <= '0;
      r_msat    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_load) begin
      if (!r_valid || m_if.m_ready) begin
        r_valid   <= 1'b1;
        r_count   <= w_snap;
        r_msat    <= w_snap_sat;
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && m_if.m_ready) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign m_if.m_valid   = r_valid;
  assign m_if.m_count   = r_count;
  assign m_if.m_sat     = r_msat;
  assign m_if.m_overrun = r_overrun;

endmodule

// File: tb/tb_ro_edge_counter.sv
// Drives a 32-bit and a 4-bit counter with identical stimulus and checks both against a window-level model.
module tb_ro_edge_counter;

  localparam int unsigned SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic ro_in;
  logic window_done;
  logic m_ready;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  ro_edge_counter_if #(.CNT_W(32)) if32 ();
  ro_edge_counter_if #(.CNT_W(4))  if4  ();

  assign if32.m_ready = m_ready;
  assign if4.m_ready  = m_ready;

  ro_edge_counter #(.CNT_W(32), .SYNC_STAGES(SYNC_STAGES)) u_dut32 (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ro_in       (ro_in),
    .window_done (window_done),
    .m_if        (if32)
  );

  ro_edge_counter #(.CNT_W(4), .SYNC_STAGES(SYNC_STAGES)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ro_in       (ro_in),
    .window_done (window_done),
    .m_if        (if4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Window-level reference: an unbounded edge tally per window, each edge
  // credited SYNC_STAGES cycles after the clock that first sees ro_in high.
  longint unsigned md_acc;
  longint unsigned md_snap;
  bit              md_valid;
  bit              md_ovr;
  bit              md_prev;
  bit              md_dly [SYNC_STAGES];

  task automatic model_reset();
    md_acc   = 0;
    md_snap  = 0;
    md_valid = 0;
    md_ovr   = 0;
    md_prev  = 0;
    for (int i = 0; i < SYNC_STAGES; i++) md_dly[i] = 0;
  endtask

  task automatic model_step();
    bit arrive;
    bit loaded;
    arrive = md_dly[SYNC_STAGES-1];
    for (int i = SYNC_STAGES-1; i > 0; i--) md_dly[i] = md_dly[i-1];
    md_dly[0] = ro_in && !md_prev;
    md_prev   = ro_in;
    loaded    = en && window_done;
    if (!en) begin
      md_acc = 0;
    end else if (window_done) begin
      if (!md_valid || m_ready) begin
        md_snap  = md_acc + arrive;
        md_valid = 1;
        md_ovr   = 0;
      end else begin
        md_ovr = 1;
      end
      md_acc = 0;
    end else begin
      md_acc = md_acc + arrive;
    end
    if (!loaded && md_valid && m_ready) begin
      md_valid = 0;
      md_ovr   = 0;
    end
  endtask

  function automatic logic [31:0] exp_count(longint unsigned raw, int unsigned w);
    longint unsigned lim;
    lim = (64'd1 << w) - 1;
    return (raw > lim) ? lim[31:0] : raw[31:0];
  endfunction

  function automatic logic [31:0] exp_sat(longint unsigned raw, int unsigned w);
    longint unsigned lim;
    lim = (64'd1 << w) - 1;
    return (raw > lim) ? 32'd1 : 32'd0;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  bit mon_on = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        check("m32.valid",   32'(if32.m_valid),   32'(md_valid));
        check("m32.count",   if32.m_count,        exp_count(md_snap, 32));
        check("m32.sat",     32'(if32.m_sat),     exp_sat(md_snap, 32));
        check("m32.overrun", 32'(if32.m_overrun), 32'(md_ovr));
        check("m4.valid",    32'(if4.m_valid),    32'(md_valid));
        check("m4.count",    32'(if4.m_count),    exp_count(md_snap, 4));
        check("m4.sat",      32'(if4.m_sat),      exp_sat(md_snap, 4));
        check("m4.overrun",  32'(if4.m_overrun),  32'(md_ovr));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_edges(input int n, input int per, input int settle);
    for (int k = 0; k < n; k++) begin
      ro_in = 1'b1;
      tick(per / 2);
      ro_in = 1'b0;
      tick(per - per / 2);
    end
    tick(settle);
  endtask

  task automatic pulse_wd();
    window_done = 1'b1;
    tick();
    window_done = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] c32,
                            input logic [31:0] c4, input logic s4, input logic ov);
    check({tag, ".v32"},  32'(if32.m_valid),   32'(v));
    check({tag, ".c32"},  if32.m_count,        c32);
    check({tag, ".ov32"}, 32'(if32.m_overrun), 32'(ov));
    check({tag, ".v4"},   32'(if4.m_valid),    32'(v));
    check({tag, ".c4"},   32'(if4.m_count),    c4);
    check({tag, ".s4"},   32'(if4.m_sat),      32'(s4));
  endtask

  localparam int SETTLE = SYNC_STAGES + 3;

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    ro_in       = 1'b0;
    window_done = 1'b0;
    m_ready     = 1'b0;
    tick(3);
    expect_out("reset", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst_n  = 1'b1;
    mon_on = 1;
    en     = 1'b1;

    // reset mid-count, with a sample pending
    drive_edges(3, 6, SETTLE);
    pulse_wd();
    expect_out("pre_rst", 1'b1, 32'd3, 32'd3, 1'b0, 1'b0);
    drive_edges(10, 6, 0);
    #2 rst_n = 1'b0;
    #1 expect_out("async_rst", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    drive_edges(5, 6, SETTLE);
    pulse_wd();
    expect_out("post_rst", 1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
    m_ready = 1'b1;
    tick();

    // basic window
    drive_edges(37, 8, SETTLE);
    pulse_wd();
    expect_out("basic", 1'b1, 32'd37, 32'd15, 1'b1, 1'b0);
    check("basic.s32", 32'(if32.m_sat), 32'd0);
    tick();
    expect_out("basic_ack", 1'b0, 32'd37, 32'd15, 1'b1, 1'b0);

    // edge reaching the accumulator in the window_done cycle
    drive_edges(11, 6, SETTLE);
    ro_in = 1'b1;
    tick(SYNC_STAGES);
    pulse_wd();
    ro_in = 1'b0;
    expect_out("boundary", 1'b1, 32'd12, 32'd12, 1'b0, 1'b0);
    tick(3);
    drive_edges(3, 6, SETTLE);
    pulse_wd();
    expect_out("after_bnd", 1'b1, 32'd3, 32'd3, 1'b0, 1'b0);
    tick();

    // backpressure and overrun
    m_ready = 1'b0;
    drive_edges(20, 4, SETTLE);
    pulse_wd();
    expect_out("bp_a", 1'b1, 32'd20, 32'd15, 1'b1, 1'b0);
    drive_edges(25, 4, SETTLE);
    pulse_wd();
    expect_out("bp_b", 1'b1, 32'd20, 32'd15, 1'b1, 1'b1);
    m_ready = 1'b1;
    tick();
    expect_out("bp_ack", 1'b0, 32'd20, 32'd15, 1'b1, 1'b0);

    // handshake and load in the same cycle
    m_ready = 1'b0;
    drive_edges(7, 6, SETTLE);
    pulse_wd();
    expect_out("sim_a", 1'b1, 32'd7, 32'd7, 1'b0, 1'b0);
    drive_edges(9, 6, SETTLE);
    m_ready = 1'b1;
    pulse_wd();
    expect_out("sim_b", 1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
    tick();
    expect_out("sim_ack", 1'b0, 32'd9, 32'd9, 1'b0, 1'b0);

    // saturation, then en dropped mid-window
    drive_edges(20, 4, SETTLE);
    pulse_wd();
    expect_out("sat", 1'b1, 32'd20, 32'd15, 1'b1, 1'b0);
    tick();
    drive_edges(6, 4, SETTLE);
    en = 1'b0;
    tick();
    pulse_wd();
    tick();
    expect_out("en_off", 1'b0, 32'd20, 32'd15, 1'b1, 1'b0);
    en = 1'b1;
    drive_edges(4, 4, SETTLE);
    pulse_wd();
    expect_out("reen", 1'b1, 32'd4, 32'd4, 1'b0, 1'b0);
    tick();

    // randomized windows: edge counts, periods, settle, ready and en all vary
    for (int w = 0; w < 24; w++) begin
      m_ready = 1'($urandom_range(0, 1));
      en      = ($urandom_range(0, 7) != 0);
      drive_edges(int'($urandom_range(0, 22)), int'($urandom_range(4, 9)),
                  int'($urandom_range(0, 4)));
      pulse_wd();
      tick(int'($urandom_range(0, 3)));
    end
    en = 1'b1;
    m_ready = 1'b1;
    tick(SETTLE);

    mon_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
